// File: rtl/seg7_pkg.sv
// Shared seven-segment definitions: active-low glyph codes (bit6=g .. bit0=a)
// and the change-event record used by the scan decoder.
package seg7_pkg;

    typedef logic [6:0] seg7_t;

    localparam seg7_t SEG_0     = 7'h40;
    localparam seg7_t SEG_1     = 7'h79;
    localparam seg7_t SEG_2     = 7'h24;
    localparam seg7_t SEG_3     = 7'h30;
    localparam seg7_t SEG_4     = 7'h19;
    localparam seg7_t SEG_5     = 7'h12;
    localparam seg7_t SEG_6     = 7'h02;
    localparam seg7_t SEG_7     = 7'h78;
    localparam seg7_t SEG_8     = 7'h00;
    localparam seg7_t SEG_9     = 7'h10;
    localparam seg7_t SEG_A     = 7'h08;
    localparam seg7_t SEG_B     = 7'h03;
    localparam seg7_t SEG_C     = 7'h46;
    localparam seg7_t SEG_D     = 7'h21;
    localparam seg7_t SEG_E     = 7'h06;
    localparam seg7_t SEG_F     = 7'h0E;
    localparam seg7_t SEG_BLANK = 7'h7F;

    // Wide enough for the largest supported digit count (16).
    localparam int MAX_DIG_W = 4;

    typedef struct packed {
        logic [MAX_DIG_W-1:0] digit;
        logic [3:0]           val;
        logic                 err;
    } event_t;

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational inverse of the hex encoder: exact pattern match to a nibble,
// anything else (blank included) flags err with val forced to 0.
module seg7_pattern_decode
    import seg7_pkg::*;
(
    input  seg7_t      seg_i,
    output logic [3:0] val_o,
    output logic       err_o
);

    always_comb begin
        // NOTE: every output gets a default before the case so no path can infer a latch.
        val_o = 4'h0;
        err_o = 1'b0;
        case (seg_i)
            SEG_0:   val_o = 4'h0;
            SEG_1:   val_o = 4'h1;
            SEG_2:   val_o = 4'h2;
            SEG_3:   val_o = 4'h3;
            SEG_4:   val_o = 4'h4;
            SEG_5:   val_o = 4'h5;
            SEG_6:   val_o = 4'h6;
            SEG_7:   val_o = 4'h7;
            SEG_8:   val_o = 4'h8;
            SEG_9:   val_o = 4'h9;
            SEG_A:   val_o = 4'hA;
            SEG_B:   val_o = 4'hB;
            SEG_C:   val_o = 4'hC;
            SEG_D:   val_o = 4'hD;
            SEG_E:   val_o = 4'hE;
            SEG_F:   val_o = 4'hF;
            default: err_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Watches a multiplexed active-low 7-seg bus, commits glitch-filtered patterns
// into a per-digit shadow table and reports changes through a one-entry event register.
module seg7_scan_decoder
    import seg7_pkg::*;
#(
    parameter  int NUM_DIGITS    = 6,
    parameter  int STABLE_CYCLES = 4,
    localparam int DIG_W         = $clog2(NUM_DIGITS)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [6:0]              seg_in,
    input  logic [DIG_W-1:0]        dig_sel,
    input  logic                    dig_en,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DIG_W-1:0]        out_digit,
    output logic [3:0]              out_val,
    output logic                    out_err,
    output logic [4*NUM_DIGITS-1:0] values,
    output logic [NUM_DIGITS-1:0]   err_mask,
    output logic                    overflow
);

    localparam int               SAMPLE_W  = DIG_W + 7;
    localparam logic [7:0]       STABLE_N  = 8'(STABLE_CYCLES);
    localparam logic [DIG_W:0]   DIGITS_N  = (DIG_W + 1)'(NUM_DIGITS);

    logic [SAMPLE_W-1:0]              sample_q, sample_d;
    logic [7:0]                       cnt_q, cnt_d;
    logic [NUM_DIGITS-1:0][3:0]       values_q;
    logic [NUM_DIGITS-1:0]            err_mask_q;
    event_t                           evt_q, new_evt;
    logic                             out_valid_q;
    logic                             overflow_q;

    logic       sample_valid, run_same, commit, changed;
    logic [3:0] dec_val;
    logic       dec_err;

    seg7_pattern_decode u_decode (
        .seg_i (seg_in),
        .val_o (dec_val),
        .err_o (dec_err)
    );

    assign sample_d     = {dig_sel, seg_in};
    assign sample_valid = dig_en && ({1'b0, dig_sel} < DIGITS_N);
    // A zero count means the previous cycle did not hold a valid sample.
    assign run_same     = (cnt_q != 8'd0) && (sample_d == sample_q);

    always_comb begin
        cnt_d = 8'd0;
        if (sample_valid) begin
            if (run_same)
                cnt_d = (cnt_q == STABLE_N) ? cnt_q : cnt_q + 8'd1;
            else
                cnt_d = 8'd1;
        end
    end

    // Commit only on the transition into saturation, so a held pattern fires once.
    assign commit  = sample_valid && (cnt_d == STABLE_N) && !(run_same && (cnt_q == STABLE_N));
    assign changed = commit && ({dec_val, dec_err} != {values_q[dig_sel], err_mask_q[dig_sel]});
    assign new_evt = '{digit: MAX_DIG_W'(dig_sel), val: dec_val, err: dec_err};

    always_ff @(posedge clk) begin
        if (reset) begin
            sample_q    <= '0;
            cnt_q       <= 8'd0;
            // NOTE: the shadow table is reset because consumers read values/err_mask directly.
            values_q    <= '0;
            err_mask_q  <= '1;
            evt_q       <= '0;
            out_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            if (sample_valid)
                sample_q <= sample_d;
            if (commit) begin
                values_q[dig_sel]   <= dec_val;
                err_mask_q[dig_sel] <= dec_err;
            end
            if (changed) begin
                if (!out_valid_q || out_ready) begin
                    evt_q       <= new_evt;
                    out_valid_q <= 1'b1;
                end else begin
                    overflow_q  <= 1'b1;
                end
            end else if (out_valid_q && out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_digit = DIG_W'(evt_q.digit);
    assign out_val   = evt_q.val;
    assign out_err   = evt_q.err;
    assign values    = values_q;
    assign err_mask  = err_mask_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Directed bench for seg7_scan_decoder: stimulus pushes expected events into a
// queue, a monitor pops and compares each event the DUT hands over.
module tb_seg7_scan_decoder;

    localparam int NUM_DIGITS = 6;
    localparam int DIG_W      = 3;

    logic                    clk = 1'b0;
    logic                    reset;
    logic [6:0]              seg_in;
    logic [DIG_W-1:0]        dig_sel;
    logic                    dig_en;
    logic                    out_valid;
    logic                    out_ready;
    logic [DIG_W-1:0]        out_digit;
    logic [3:0]              out_val;
    logic                    out_err;
    logic [4*NUM_DIGITS-1:0] values;
    logic [NUM_DIGITS-1:0]   err_mask;
    logic                    overflow;

    typedef struct {
        int digit;
        int val;
        int err;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    seg7_scan_decoder #(.NUM_DIGITS(NUM_DIGITS), .STABLE_CYCLES(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .seg_in    (seg_in),
        .dig_sel   (dig_sel),
        .dig_en    (dig_en),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_digit (out_digit),
        .out_val   (out_val),
        .out_err   (out_err),
        .values    (values),
        .err_mask  (err_mask),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input int d, input int v, input int e);
        exp_t x;
        x.digit = d;
        x.val   = v;
        x.err   = e;
        exp_q.push_back(x);
    endtask

    // Holds one bus value for n clock edges; returns 1 time unit after the last edge.
    task automatic drive(input int sel, input logic [6:0] seg, input logic en, input int n);
        dig_sel = DIG_W'(sel);
        seg_in  = seg;
        dig_en  = en;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        dig_en = 1'b0;
        reset  = 1'b1;
        @(posedge clk);
        #1;
        reset  = 1'b0;
        exp_q.delete();
    endtask

    task automatic drain();
        int k = 0;
        dig_en = 1'b0;
        while ((exp_q.size() != 0 || out_valid) && k < 50) begin
            @(posedge clk);
            #1;
            k++;
        end
        check("drain_queue_empty", exp_q.size(), 0);
    endtask

    // Monitor: an event is consumed on the edge after a negedge seeing valid && ready.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_event: got digit %0d val %0h err %0b, expected none",
                             out_digit, out_val, out_err);
                end else begin
                    e = exp_q.pop_front();
                    check("evt_digit", out_digit, e.digit);
                    check("evt_val", out_val, e.val);
                    check("evt_err", out_err, e.err);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [6:0] pat [16];
        pat = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

        reset     = 1'b1;
        dig_en    = 1'b0;
        dig_sel   = '0;
        seg_in    = 7'h7F;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        check("rst_values", values, 0);
        check("rst_err_mask", err_mask, 6'h3F);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_digit", out_digit, 0);
        check("rst_out_val", out_val, 0);
        check("rst_out_err", out_err, 0);
        check("rst_overflow", overflow, 0);

        // Commit latency: four identical samples.
        push(2, 2, 0);
        drive(2, 7'h24, 1'b1, 3);
        check("t1_no_early_valid", out_valid, 0);
        check("t1_no_early_mask", err_mask[2], 1);
        drive(2, 7'h24, 1'b1, 1);
        check("t1_value", values[11:8], 2);
        check("t1_mask", err_mask[2], 0);
        check("t1_valid", out_valid, 1);
        check("t1_digit", out_digit, 2);
        check("t1_val", out_val, 2);
        check("t1_err", out_err, 0);
        drain();

        // Short glitch run, then a held pattern that must fire once only.
        do_reset();
        drive(2, 7'h24, 1'b1, 3);
        push(2, 3, 0);
        drive(2, 7'h30, 1'b1, 4);
        check("t2_value", values[11:8], 3);
        drive(2, 7'h30, 1'b1, 20);
        check("t2_value_held", values[11:8], 3);
        drain();

        // Blank is unrecognised and matches the reset entry: no event.
        drive(0, 7'h7F, 1'b1, 4);
        check("t3_blank_mask", err_mask[0], 1);
        check("t3_blank_value", values[3:0], 0);
        check("t3_blank_no_evt", out_valid, 0);
        push(0, 0, 0);
        drive(0, 7'h40, 1'b1, 4);
        check("t3_zero_mask", err_mask[0], 0);
        drain();

        // Back-pressure: second event dropped, table still written.
        out_ready = 1'b0;
        push(1, 1, 0);
        drive(1, 7'h79, 1'b1, 4);
        drive(3, 7'h78, 1'b1, 4);
        check("t4_valid", out_valid, 1);
        check("t4_digit", out_digit, 1);
        check("t4_val", out_val, 1);
        check("t4_err", out_err, 0);
        check("t4_overflow", overflow, 1);
        check("t4_value3", values[15:12], 7);
        check("t4_mask3", err_mask[3], 0);
        dig_en    = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("t4_valid_clear", out_valid, 0);
        check("t4_overflow_sticky", overflow, 1);
        drain();

        // Accept and new commit on the same edge: no bubble, no drop.
        do_reset();
        out_ready = 1'b0;
        push(4, 4, 0);
        drive(4, 7'h19, 1'b1, 4);
        push(5, 5, 0);
        drive(5, 7'h12, 1'b1, 3);
        out_ready = 1'b1;
        drive(5, 7'h12, 1'b1, 1);
        check("t5_valid", out_valid, 1);
        check("t5_digit", out_digit, 5);
        check("t5_val", out_val, 5);
        check("t5_overflow", overflow, 0);
        drain();

        // Out-of-range digit and toggling enable never commit.
        drive(7, 7'h40, 1'b1, 8);
        check("t6_range_values", values, 24'h540000);
        check("t6_range_mask", err_mask, 6'h0F);
        check("t6_range_no_evt", out_valid, 0);
        for (int i = 0; i < 6; i++) begin
            drive(1, 7'h24, 1'b1, 1);
            drive(1, 7'h24, 1'b0, 1);
        end
        check("t6_toggle_value", values[7:4], 0);
        check("t6_toggle_mask", err_mask[1], 1);

        // Reset at count 3 discards the partial run.
        drive(0, 7'h79, 1'b1, 3);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        exp_q.delete();
        check("t6_rst_mask", err_mask, 6'h3F);
        check("t6_rst_values", values, 0);
        drive(0, 7'h79, 1'b1, 3);
        check("t6_rerun_no_commit", err_mask[0], 1);
        check("t6_rerun_no_evt", out_valid, 0);
        push(0, 1, 0);
        drive(0, 7'h79, 1'b1, 1);
        check("t6_rerun_commit", err_mask[0], 0);
        drain();

        // Round-trip sweep of all encoder glyphs.
        do_reset();
        for (int i = 0; i < 16; i++) begin
            push(i % 6, i, 0);
            drive(i % 6, pat[i], 1'b1, 4);
            check($sformatf("sweep_val_%0d", i), out_val, i);
            check($sformatf("sweep_valid_%0d", i), out_valid, 1);
        end
        check("sweep_values", values, 24'hBAFEDC);
        check("sweep_mask", err_mask, 6'h00);
        drain();

        // A near-miss pattern is not decoded.
        push(0, 0, 1);
        drive(0, 7'h41, 1'b1, 4);
        check("nearmiss_mask", err_mask[0], 1);
        check("nearmiss_value", values[3:0], 0);
        check("nearmiss_err", out_err, 1);
        drain();

        check("final_overflow", overflow, 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
